// File: rtl/csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_unit
// Purpose  : Machine-mode CSR file and trap responder (interrupt entry, mret),
//            driving a registered fetch redirect and pipeline flush.
// Options  : CSR_CYCLE_COUNTER_EN adds the 64-bit mcycle/mcycleh counter.
// Revision : 1.0  initial release
// ============================================================================
module csr_trap_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             csr_reg_rd,
    input  logic             csr_reg_wr,
    input  logic             is_mret,
    input  logic [11:0]      csr_addr,
    input  logic [WIDTH-1:0] csr_wdata,
    input  logic [WIDTH-1:0] pc_m,
    input  logic             ext_irq,
    input  logic             timer_irq,
    output logic [WIDTH-1:0] csr_rdata,
    output logic             redirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             flush
);

    localparam logic [11:0]      c_addr_mstatus = 12'h300;
    localparam logic [11:0]      c_addr_mie     = 12'h304;
    localparam logic [11:0]      c_addr_mtvec   = 12'h305;
    localparam logic [11:0]      c_addr_mepc    = 12'h341;
    localparam logic [11:0]      c_addr_mcause  = 12'h342;
    localparam logic [11:0]      c_addr_mip     = 12'h344;
    localparam logic [11:0]      c_addr_mcycle  = 12'hB00;
    localparam logic [11:0]      c_addr_mcycleh = 12'hB80;
    localparam logic [WIDTH-1:0] c_cause_mei    = WIDTH'(11);
    localparam logic [WIDTH-1:0] c_cause_mti    = WIDTH'(7);
    localparam logic [WIDTH-1:0] c_irq_flag     = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [0:0] c_st_run  = 1'b0;
    localparam logic [0:0] c_st_hold = 1'b1;

    logic [0:0]       r_state;
    logic             r_mstatus_mie;
    logic             r_mstatus_mpie;
    logic             r_mie_mtie;
    logic             r_mie_meie;
    logic             r_mip_mtip;
    logic             r_mip_meip;
    logic [WIDTH-1:0] r_mtvec;
    logic [WIDTH-1:0] r_mepc;
    logic [WIDTH-1:0] r_mcause;
    logic             r_redirect;
    logic             r_flush;
    logic [WIDTH-1:0] r_redirect_pc;

    logic             w_run;
    logic             w_mei_pend;
    logic             w_mti_pend;
    logic             w_trap;
    logic             w_wr;
    logic [WIDTH-1:0] w_cause;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_trap_pc;
    logic [WIDTH-1:0] w_rdata;

    assign w_run      = (r_state == c_st_run);
    assign w_mei_pend = r_mie_meie & r_mip_meip;
    assign w_mti_pend = r_mie_mtie & r_mip_mtip;
    // mret has priority; a pending interrupt is re-evaluated once HOLD ends
    assign w_trap     = w_run & ~is_mret & r_mstatus_mie & (w_mei_pend | w_mti_pend);
    // the trapped instruction re-executes after return, so its write is dropped
    assign w_wr       = csr_reg_wr & w_run & ~w_trap;
    assign w_cause    = w_mei_pend ? c_cause_mei : c_cause_mti;
    assign w_base     = {r_mtvec[WIDTH-1:2], 2'b00};
    assign w_trap_pc  = r_mtvec[0] ? (w_base + (w_cause << 2)) : w_base;

`ifdef CSR_CYCLE_COUNTER_EN
    localparam logic [2*WIDTH-1:0] c_cycle_one = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] r_mcycle;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcycle <= '0;
        end else if (w_wr && (csr_addr == c_addr_mcycle)) begin
            r_mcycle[WIDTH-1:0] <= csr_wdata;
        end else if (w_wr && (csr_addr == c_addr_mcycleh)) begin
            r_mcycle[2*WIDTH-1:WIDTH] <= csr_wdata;
        end else begin
            r_mcycle <= r_mcycle + c_cycle_one;
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        if (csr_reg_rd) begin
            case (csr_addr)
                c_addr_mstatus: begin
                    w_rdata[7] = r_mstatus_mpie;
                    w_rdata[3] = r_mstatus_mie;
                end
                c_addr_mie: begin
                    w_rdata[11] = r_mie_meie;
                    w_rdata[7]  = r_mie_mtie;
                end
                c_addr_mtvec:   w_rdata = r_mtvec;
                c_addr_mepc:    w_rdata = r_mepc;
                c_addr_mcause:  w_rdata = r_mcause;
                c_addr_mip: begin
                    w_rdata[11] = r_mip_meip;
                    w_rdata[7]  = r_mip_mtip;
                end
`ifdef CSR_CYCLE_COUNTER_EN
                c_addr_mcycle:  w_rdata = r_mcycle[WIDTH-1:0];
                c_addr_mcycleh: w_rdata = r_mcycle[2*WIDTH-1:WIDTH];
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_st_run;
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_mtie     <= 1'b0;
            r_mie_meie     <= 1'b0;
            r_mip_mtip     <= 1'b0;
            r_mip_meip     <= 1'b0;
            r_mtvec        <= RESET_VEC;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_redirect     <= 1'b0;
            r_flush        <= 1'b0;
            r_redirect_pc  <= '0;
        end else begin
            r_mip_meip <= ext_irq;
            r_mip_mtip <= timer_irq;
            r_redirect <= 1'b0;
            r_flush    <= 1'b0;

            if (w_wr) begin
                case (csr_addr)
                    c_addr_mstatus: begin
                        r_mstatus_mie  <= csr_wdata[3];
                        r_mstatus_mpie <= csr_wdata[7];
                    end
                    c_addr_mie: begin
                        r_mie_mtie <= csr_wdata[7];
                        r_mie_meie <= csr_wdata[11];
                    end
                    c_addr_mtvec:  r_mtvec  <= {csr_wdata[WIDTH-1:2], 1'b0, csr_wdata[0]};
                    c_addr_mepc:   r_mepc   <= {csr_wdata[WIDTH-1:2], 2'b00};
                    c_addr_mcause: r_mcause <= csr_wdata;
                    default: ;
                endcase
            end

            case (r_state)
                c_st_run: begin
                    if (is_mret) begin
                        r_mstatus_mie  <= r_mstatus_mpie;
                        r_mstatus_mpie <= 1'b1;
                        r_redirect_pc  <= r_mepc;
                        r_redirect     <= 1'b1;
                        r_flush        <= 1'b1;
                        r_state        <= c_st_hold;
                    end else if (w_trap) begin
                        r_mepc         <= {pc_m[WIDTH-1:2], 2'b00};
                        r_mcause       <= c_irq_flag | w_cause;
                        r_mstatus_mpie <= r_mstatus_mie;
                        r_mstatus_mie  <= 1'b0;
                        r_redirect_pc  <= w_trap_pc;
                        r_redirect     <= 1'b1;
                        r_flush        <= 1'b1;
                        r_state        <= c_st_hold;
                    end
                end
                c_st_hold: r_state <= c_st_run;
                default:   r_state <= c_st_run;
            endcase
        end
    end

    assign csr_rdata   = w_rdata;
    assign redirect    = r_redirect;
    assign flush       = r_flush;
    assign redirect_pc = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_trap_unit
// Purpose  : Directed and randomized bench for csr_trap_unit against a
//            register-level reference model of the CSR/trap rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_csr_trap_unit;

    localparam int unsigned WIDTH     = 32;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_reg_rd;
    logic        csr_reg_wr;
    logic        is_mret;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] pc_m;
    logic        ext_irq;
    logic        timer_irq;
    logic [31:0] csr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;

    csr_trap_unit #(
        .WIDTH     (WIDTH),
        .RESET_VEC (RESET_VEC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .csr_reg_rd  (csr_reg_rd),
        .csr_reg_wr  (csr_reg_wr),
        .is_mret     (is_mret),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .pc_m        (pc_m),
        .ext_irq     (ext_irq),
        .timer_irq   (timer_irq),
        .csr_rdata   (csr_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: whole architectural registers as read back by software
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mip, m_rpc;
    logic [63:0] m_mcycle;
    bit          m_hold, m_redirect;

    logic [31:0] obs_rdata, obs_rpc;
    logic        obs_redirect;
    bit          cur_ext, cur_tmr;
    logic [31:0] cur_pc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
`ifdef CSR_CYCLE_COUNTER_EN
            12'hB00: return m_mcycle[31:0];
            12'hB80: return m_mcycle[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mstatus = 0; m_mie = 0; m_mtvec = RESET_VEC; m_mepc = 0;
        m_mcause = 0; m_mip = 0; m_mcycle = 0; m_hold = 0; m_redirect = 0;
    endtask

    task automatic model_step(input bit wr, input bit mret, input logic [11:0] addr,
                              input logic [31:0] wdata, input logic [31:0] pc,
                              input bit ext, input bit tmr);
        logic [31:0] pend, old_mstatus, old_mepc, cause, base;
        bit take_mret, take_trap, take_wr, cnt_written;
        old_mstatus = m_mstatus;
        old_mepc    = m_mepc;
        pend        = m_mie & m_mip;
        take_mret   = !m_hold && mret;
        take_trap   = !m_hold && !mret && old_mstatus[3] && (pend != 0);
        take_wr     = wr && !m_hold && !take_trap;
        cnt_written = 0;
        if (take_wr) begin
            case (addr)
                12'h300: m_mstatus = wdata & 32'h0000_0088;
                12'h304: m_mie     = wdata & 32'h0000_0880;
                12'h305: m_mtvec   = wdata & ~32'h2;
                12'h341: m_mepc    = wdata & ~32'h3;
                12'h342: m_mcause  = wdata;
`ifdef CSR_CYCLE_COUNTER_EN
                12'hB00: begin m_mcycle[31:0]  = wdata; cnt_written = 1; end
                12'hB80: begin m_mcycle[63:32] = wdata; cnt_written = 1; end
`endif
                default: ;
            endcase
        end
        if (!cnt_written) m_mcycle = m_mcycle + 64'd1;
        if (take_mret) begin
            m_rpc     = old_mepc;
            m_mstatus = 32'h80 | (old_mstatus[7] ? 32'h8 : 32'h0);
        end
        if (take_trap) begin
            cause     = pend[11] ? 32'd11 : 32'd7;
            base      = m_mtvec & ~32'h3;
            m_rpc     = m_mtvec[0] ? base + cause * 4 : base;
            m_mepc    = pc & ~32'h3;
            m_mcause  = 32'h8000_0000 | cause;
            m_mstatus = old_mstatus[3] ? 32'h80 : 32'h0;
        end
        m_redirect = take_mret || take_trap;
        m_hold     = m_redirect;
        m_mip      = (ext ? 32'h800 : 32'h0) | (tmr ? 32'h80 : 32'h0);
    endtask

    // One clock: drive after the falling edge, check read data, then check the edge's outputs
    task automatic cycle(input bit rd, input bit wr, input bit mret, input logic [11:0] addr,
                         input logic [31:0] wdata);
        logic [31:0] exp_rd;
        csr_reg_rd = rd; csr_reg_wr = wr; is_mret = mret; csr_addr = addr;
        csr_wdata = wdata; pc_m = cur_pc; ext_irq = cur_ext; timer_irq = cur_tmr;
        #1;
        exp_rd    = rd ? model_read(addr) : 32'h0;
        obs_rdata = csr_rdata;
        check_val($sformatf("rdata@%03h", addr), csr_rdata, exp_rd);
        @(posedge clk);
        model_step(wr, mret, addr, wdata, cur_pc, cur_ext, cur_tmr);
        #1;
        obs_redirect = redirect;
        obs_rpc      = redirect_pc;
        check_val("redirect", {31'b0, redirect}, {31'b0, m_redirect});
        check_val("flush", {31'b0, flush}, {31'b0, m_redirect});
        if (m_redirect) check_val("redirect_pc", redirect_pc, m_rpc);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 12'h000, 32'h0);
    endtask

    task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
        cycle(0, 1, 0, a, d);
    endtask

    task automatic rd_csr(input logic [11:0] a);
        cycle(1, 0, 0, a, 32'h0);
    endtask

    task automatic do_reset(input int n);
        reset = 1; csr_reg_rd = 0; csr_reg_wr = 0; is_mret = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_reset();
            #1;
            check_val("rst_redirect", {31'b0, redirect}, 32'h0);
            check_val("rst_flush", {31'b0, flush}, 32'h0);
        end
        @(negedge clk);
        reset = 0;
    endtask

    logic [11:0] addr_pool [10];

    initial begin
        logic [11:0] a;
        addr_pool = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                      12'h344, 12'hB00, 12'hB80, 12'h343, 12'h7C0};
        reset = 1; csr_reg_rd = 0; csr_reg_wr = 0; is_mret = 0; csr_addr = 0;
        csr_wdata = 0; pc_m = 0; ext_irq = 0; timer_irq = 0;
        cur_ext = 0; cur_tmr = 0; cur_pc = 0;
        do_reset(3);

        for (int i = 0; i < 6; i++) begin
            rd_csr(addr_pool[i]);
            check_val("rst_csr", obs_rdata, (addr_pool[i] == 12'h305) ? RESET_VEC : 32'h0);
        end

        // direct-mode external interrupt
        wr_csr(12'h305, 32'h100);
        wr_csr(12'h304, 32'h800);
        cur_ext = 1;
        wr_csr(12'h300, 32'h8);
        cur_pc = 32'h40;
        idle();
        check_val("trap_redirect", {31'b0, obs_redirect}, 32'h1);
        check_val("trap_pc", obs_rpc, 32'h100);
        rd_csr(12'h341); check_val("trap_mepc", obs_rdata, 32'h40);
        rd_csr(12'h342); check_val("trap_mcause", obs_rdata, 32'h8000_000B);
        rd_csr(12'h300); check_val("trap_mstatus", obs_rdata, 32'h80);

        // mret with the interrupt still pending: taken only after HOLD
        cur_pc = 32'h80;
        cycle(0, 0, 1, 12'h000, 32'h0);
        check_val("mret_pc", obs_rpc, 32'h40);
        rd_csr(12'h300);
        check_val("mret_mstatus", obs_rdata, 32'h88);
        check_val("hold_no_trap", {31'b0, obs_redirect}, 32'h0);
        idle();
        check_val("post_hold_trap", {31'b0, obs_redirect}, 32'h1);

        // vectored mode, both interrupts: external wins
        idle();
        wr_csr(12'h305, 32'h101);
        cur_tmr = 1;
        wr_csr(12'h304, 32'h880);
        wr_csr(12'h300, 32'h8);
        idle();
        check_val("vec_pc", obs_rpc, 32'h12C);

        // reset while redirect is asserted
        do_reset(1);
        for (int i = 0; i < 10; i++) idle();
        rd_csr(12'hB00);
`ifdef CSR_CYCLE_COUNTER_EN
        check_val("mcycle10", obs_rdata, 32'd10);
`else
        check_val("mcycle_unmapped", obs_rdata, 32'h0);
`endif

        // unmapped and read-only targets
        wr_csr(12'h343, 32'hDEAD_BEEF);
        wr_csr(12'h344, 32'hFFFF_FFFF);
        rd_csr(12'h344); check_val("mip_ro", obs_rdata, 32'h880);
        rd_csr(12'h343); check_val("unmapped_rd", obs_rdata, 32'h0);
        wr_csr(12'h341, 32'h13);
        rd_csr(12'h341); check_val("mepc_align", obs_rdata, 32'h10);

        wr_csr(12'hB00, 32'hFFFF_FFFF);
        idle();
        rd_csr(12'hB80);
`ifdef CSR_CYCLE_COUNTER_EN
        check_val("mcycleh_carry", obs_rdata, 32'h1);
`else
        check_val("mcycleh_unmapped", obs_rdata, 32'h0);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1);
            end else begin
                a = ($urandom_range(0, 9) == 9) ? 12'($urandom) : addr_pool[$urandom_range(0, 8)];
                if ($urandom_range(0, 19) == 0) cur_ext = ~cur_ext;
                if ($urandom_range(0, 19) == 0) cur_tmr = ~cur_tmr;
                cur_pc = $urandom & ~32'h3;
                cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 15) == 0), a, $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
